// File: rtl/accu_if.sv
// accu_if: streaming handshake bundle for the accu group-sum accumulator.
//   Upstream   : data_in, valid_a (producer -> accu), ready_a (accu -> producer)
//   Downstream : data_out, valid_b (accu -> consumer), ready_b (consumer -> accu)
// Modports:
//   slave  - the accumulator side (consumes data_in, produces data_out)
//   master - the testbench/system side that drives data_in and ready_b
// DATA_W/OUT_W must match the parameters of the accu instance it connects to.
interface accu_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 10
);
  logic [DATA_W-1:0] data_in;
  logic              valid_a;
  logic              ready_a;
  logic [OUT_W-1:0]  data_out;
  logic              valid_b;
  logic              ready_b;

  modport slave (
    input  data_in, valid_a, ready_b,
    output ready_a, valid_b, data_out
  );

  modport master (
    output data_in, valid_a, ready_b,
    input  ready_a, valid_b, data_out
  );
endinterface

// File: rtl/accu.sv
// accu: streaming accumulator; sums each group of NUM consecutive accepted
// input beats and presents the sum with a valid/ready handshake.
//   clk      - rising-edge clock
//   rst_n    - synchronous active-low reset
//   bus      - accu_if.slave: data_in/valid_a/ready_a upstream,
//              data_out/valid_b/ready_b downstream
//   beat_cnt - (only with ACCU_BEAT_CNT_EN defined) registered beat counter
// data_out always shows the running partial sum; valid_b flags that it holds
// a complete NUM-beat sum. A delivery and the first beat of the next group may
// share a cycle, so throughput is one beat per cycle while ready_b is high.
// Optional feature macro: ACCU_BEAT_CNT_EN (exposes the beat counter).
module accu #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 10,
  parameter int NUM    = 4,
  localparam int CNT_W = $clog2(NUM + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ACCU_BEAT_CNT_EN
  output logic [CNT_W-1:0] beat_cnt,
`endif
  accu_if.slave            bus
);

  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] sum_q;
  logic             vld_q;
  logic             acc, done, start, last;

  // Upstream is only stalled while a finished sum waits for the consumer.
  assign bus.ready_a  = ~vld_q | bus.ready_b;
  assign acc          = bus.valid_a & bus.ready_a;
  assign done         = vld_q & bus.ready_b;
  // A pending sum being taken this cycle frees data_out for a new group.
  assign start        = (cnt == '0) | done;
  assign last         = ~start & (cnt == CNT_W'(NUM - 1));

  assign bus.data_out = sum_q;
  assign bus.valid_b  = vld_q;

`ifdef ACCU_BEAT_CNT_EN
  assign beat_cnt = cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
      vld_q <= 1'b0;
      cnt   <= '0;
    end else begin
      if (done) vld_q <= 1'b0;
      if (acc) begin
        if (start) begin
          sum_q <= OUT_W'(bus.data_in);
          cnt   <= CNT_W'(1);
        end else begin
          sum_q <= sum_q + OUT_W'(bus.data_in);
          if (last) begin
            cnt   <= '0;
            vld_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_accu.sv
module tb_accu;
  localparam int DATA_W = 8;
  localparam int OUT_W  = 10;
  localparam int NUM    = 4;
  localparam int CNT_W  = $clog2(NUM + 1);

  typedef struct {
    logic [OUT_W-1:0] dout;
    logic             vb;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;
  exp_t sb[$];

  accu_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

`ifdef ACCU_BEAT_CNT_EN
  logic [CNT_W-1:0] beat_cnt;
  accu #(.DATA_W(DATA_W), .OUT_W(OUT_W), .NUM(NUM)) dut (
    .clk(clk), .rst_n(rst_n), .beat_cnt(beat_cnt), .bus(bus)
  );
`else
  accu #(.DATA_W(DATA_W), .OUT_W(OUT_W), .NUM(NUM)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, check the combinational ready_a, push the
  // expected post-edge state, then pop and compare after the edge.
  task automatic step(input logic r, input logic v, input logic [DATA_W-1:0] d,
                      input logic rb, input logic e_ra, input logic [OUT_W-1:0] e_dout,
                      input logic e_vb, input logic [CNT_W-1:0] e_cnt, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n       = r;
    bus.valid_a = v;
    bus.data_in = d;
    bus.ready_b = rb;
    #1;
    chk({tag, ".ready_a"}, 32'(bus.ready_a), 32'(e_ra));
    e.dout = e_dout; e.vb = e_vb; e.cnt = e_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'(0), 32'(1));
    end else begin
      e = sb.pop_front();
      chk({tag, ".data_out"}, 32'(bus.data_out), 32'(e.dout));
      chk({tag, ".valid_b"},  32'(bus.valid_b),  32'(e.vb));
`ifdef ACCU_BEAT_CNT_EN
      chk({tag, ".beat_cnt"}, 32'(beat_cnt), 32'(e.cnt));
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.valid_a = 1'b0; bus.data_in = '0; bus.ready_b = 1'b0;
    //     rst v  din rb  ra  dout vb cnt
    step(0, 0, 0,  0,  1,  0,   0, 0, "reset");
    // fill a group under no downstream readiness
    step(1, 1, 1,  0,  1,  1,   0, 1, "g1b1");
    step(1, 1, 2,  0,  1,  3,   0, 2, "g1b2");
    step(1, 1, 3,  0,  1,  6,   0, 3, "g1b3");
    step(1, 1, 4,  0,  1,  10,  1, 0, "g1b4");
    // backpressure: input stalled, sum held
    step(1, 1, 5,  0,  0,  10,  1, 0, "bp1");
    step(1, 1, 5,  0,  0,  10,  1, 0, "bp2");
    // delivery and first beat of next group in the same cycle
    step(1, 1, 5,  1,  1,  5,   0, 1, "g2b1");
    step(1, 1, 2,  1,  1,  7,   0, 2, "g2b2");
    step(1, 1, 3,  1,  1,  10,  0, 3, "g2b3");
    // bubble mid-group
    step(1, 0, 9,  1,  1,  10,  0, 3, "bubble");
    step(1, 1, 5,  1,  1,  15,  1, 0, "g2b4");
    // back-to-back groups
    step(1, 1, 6,  1,  1,  6,   0, 1, "g3b1");
    step(1, 1, 6,  1,  1,  12,  0, 2, "g3b2");
    // reset mid-group discards partial sum
    step(0, 1, 7,  1,  1,  0,   0, 0, "rst_mid");
    step(1, 1, 8,  0,  1,  8,   0, 1, "g4b1");
    step(1, 1, 1,  0,  1,  9,   0, 2, "g4b2");
    step(1, 1, 1,  0,  1,  10,  0, 3, "g4b3");
    step(1, 1, 1,  1,  1,  11,  1, 0, "g4b4");
    // delivery without a new beat: valid drops, data_out held
    step(1, 0, 0,  1,  1,  11,  0, 0, "drain");
    // ready_b with nothing pending is harmless; next beat overwrites
    step(1, 0, 0,  1,  1,  11,  0, 0, "idle_rb");
    step(1, 1, 2,  0,  1,  2,   0, 1, "g5b1");
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
